// File: rtl/out_port_tracker_pkg.sv
// Shared defaults and types for the output-port availability tracker.
// Router, allocator and downstream buffer import these so their depths agree.
package out_port_tracker_pkg;

    localparam int NUM_PORT_DEF   = 5;
    localparam int CREDIT_MAX_DEF = 4;
    localparam int CW_DEF         = 3;
    localparam int SER_CYC_DEF    = 2;

    // Wide enough for the largest legal occupancy count (SER_CYC-1 = 14).
    localparam int SER_W = 4;

    typedef enum logic [1:0] {
        EV_IDLE,
        EV_ACCEPT,
        EV_ILLEGAL
    } grant_ev_e;

endpackage

// File: rtl/out_port_tracker_if.sv
// Allocator-facing bundle of the tracker: grants and credits in, availability out.
interface out_port_tracker_if
    import out_port_tracker_pkg::*;
#(
    parameter int NUM_PORT = NUM_PORT_DEF,
    parameter int CW       = CW_DEF
);

    logic [NUM_PORT-1:0]    alloc;
    logic [NUM_PORT-1:0]    credit_ret;
    logic [NUM_PORT-1:0]    port_en;
    logic [NUM_PORT-1:0]    avail;
    logic [NUM_PORT*CW-1:0] credit_cnt;
    logic                   err;

    modport master (
        output alloc, credit_ret, port_en,
        input  avail, credit_cnt, err
    );

    modport slave (
        input  alloc, credit_ret, port_en,
        output avail, credit_cnt, err
    );

endinterface

// File: rtl/out_port_tracker_port_credit_ctr.sv
// One output port: downstream credit count, link occupancy, availability and
// a single-cycle protocol-error pulse (illegal grant or credit overflow).
module port_credit_ctr
    import out_port_tracker_pkg::*;
#(
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int CW         = CW_DEF,
    parameter int SER_CYC    = SER_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          alloc,
    input  logic          credit_ret,
    output logic          avail,
    output logic [CW-1:0] cred,
    output logic          err_pulse
);

    localparam logic [CW-1:0]    CRED_FULL = CW'(CREDIT_MAX);
    localparam logic [SER_W-1:0] SER_LOAD  = SER_W'(SER_CYC - 1);

    logic [SER_W-1:0] ser;
    logic [SER_W-1:0] ser_nxt;
    logic [CW-1:0]    cred_nxt;
    logic             overflow;
    grant_ev_e        ev;

    // Registers only: the allocator may feed alloc straight back from avail.
    assign avail = en & (cred != '0) & (ser == '0);

    always_comb begin
        ev = EV_IDLE;
        if (alloc) ev = avail ? EV_ACCEPT : EV_ILLEGAL;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        cred_nxt = cred;
        ser_nxt  = ser;
        overflow = 1'b0;
        if (ev == EV_ACCEPT) begin
            ser_nxt = SER_LOAD;
            if (!credit_ret) cred_nxt = cred - CW'(1);
        end else begin
            if (ser != '0) ser_nxt = ser - SER_W'(1);
            if (credit_ret) begin
                if (cred == CRED_FULL) overflow = 1'b1;
                else                   cred_nxt = cred + CW'(1);
            end
        end
    end

    assign err_pulse = (ev == EV_ILLEGAL) | overflow;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            cred <= CRED_FULL;
            ser  <= '0;
        end else begin
            cred <= cred_nxt;
            ser  <= ser_nxt;
        end
    end

endmodule

// File: rtl/out_port_tracker.sv
// Output-port availability tracker for switch allocation: one credit/occupancy
// counter per port plus a sticky protocol-error flag.
module out_port_tracker
    import out_port_tracker_pkg::*;
#(
    parameter int NUM_PORT   = NUM_PORT_DEF,
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int CW         = CW_DEF,
    parameter int SER_CYC    = SER_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    out_port_tracker_if.slave  bus
);

    logic [NUM_PORT-1:0]    avail_v;
    logic [NUM_PORT-1:0]    err_v;
    logic [NUM_PORT*CW-1:0] cnt_v;
    logic                   err_q;

    for (genvar i = 0; i < NUM_PORT; i++) begin : g_port
        port_credit_ctr #(
            .CREDIT_MAX (CREDIT_MAX),
            .CW         (CW),
            .SER_CYC    (SER_CYC)
        ) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .en         (bus.port_en[i]),
            .alloc      (bus.alloc[i]),
            .credit_ret (bus.credit_ret[i]),
            .avail      (avail_v[i]),
            .cred       (cnt_v[i*CW +: CW]),
            .err_pulse  (err_v[i])
        );
    end

    // Sticky until reset so software can see a single violation long after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       err_q <= 1'b0;
        else if (|err_v) err_q <= 1'b1;
    end

    assign bus.avail      = avail_v;
    assign bus.credit_cnt = cnt_v;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_out_port_tracker.sv
// Self-checking bench for out_port_tracker: directed scenarios plus random
// traffic against a credit/free-at-cycle reference model.
module tb_out_port_tracker;

    localparam int NP      = 5;
    localparam int CMAX    = 4;
    localparam int CW      = 3;
    localparam int SER_CYC = 2;

    logic clk = 1'b0;
    logic reset;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: credits as integers, occupancy as "first free cycle".
    int cred [NP];
    int next_free [NP];
    int cyc = 0;
    bit m_err;

    out_port_tracker_if #(.NUM_PORT(NP), .CW(CW)) bus ();

    out_port_tracker #(
        .NUM_PORT   (NP),
        .CREDIT_MAX (CMAX),
        .CW         (CW),
        .SER_CYC    (SER_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            cred[i]      = CMAX;
            next_free[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NP; i++) begin
            bit av;
            bit acc;
            int nc;
            av  = bus.port_en[i] && cred[i] > 0 && cyc >= next_free[i];
            acc = bus.alloc[i] && av;
            if (bus.alloc[i] && !av) m_err = 1'b1;
            if (acc) next_free[i] = cyc + SER_CYC;
            nc = cred[i] - int'(acc) + int'(bus.credit_ret[i]);
            if (nc > CMAX) begin
                nc    = CMAX;
                m_err = 1'b1;
            end
            cred[i] = nc;
        end
    endtask

    function automatic logic [NP-1:0] exp_avail();
        logic [NP-1:0] e;
        for (int i = 0; i < NP; i++)
            e[i] = bus.port_en[i] && cred[i] > 0 && cyc >= next_free[i];
        return e;
    endfunction

    function automatic logic [NP*CW-1:0] exp_cnt();
        logic [NP*CW-1:0] e;
        for (int i = 0; i < NP; i++) e[i*CW +: CW] = CW'(cred[i]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        bus.port_en = 5'b11111;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        compared++;
        if (bus.avail !== 5'b11111) begin
            mismatched++;
            $display("FAIL reset_avail: got %b want 11111", bus.avail);
        end
        compared++;
        if (bus.credit_cnt !== 15'o44444) begin
            mismatched++;
            $display("FAIL reset_cnt: got %o want 44444", bus.credit_cnt);
        end
        compared++;
        if (bus.err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_err: got %b want 0", bus.err);
        end
    endtask

    task automatic test_serialization();
        bus.alloc = 5'b10000;
        tick();
        bus.alloc = '0;
        compared++;
        if (bus.avail !== 5'b01111) begin
            mismatched++;
            $display("FAIL ser_busy: got %b want 01111", bus.avail);
        end
        compared++;
        if (bus.credit_cnt[12 +: 3] !== 3'd3) begin
            mismatched++;
            $display("FAIL ser_cred4: got %0d want 3", bus.credit_cnt[12 +: 3]);
        end
        tick();
        compared++;
        if (bus.avail !== 5'b11111) begin
            mismatched++;
            $display("FAIL ser_free: got %b want 11111", bus.avail);
        end
    endtask

    task automatic test_exhaustion();
        for (int k = 0; k < CMAX; k++) begin
            bus.alloc = 5'b00001;
            tick();
            bus.alloc = '0;
            tick();
        end
        compared++;
        if (bus.avail[0] !== 1'b0 || bus.credit_cnt[0 +: 3] !== 3'd0) begin
            mismatched++;
            $display("FAIL exhaust_empty: avail0=%b cred0=%0d want 0/0", bus.avail[0], bus.credit_cnt[0 +: 3]);
        end
        bus.credit_ret = 5'b00001;
        tick();
        bus.credit_ret = '0;
        compared++;
        if (bus.avail[0] !== 1'b1 || bus.credit_cnt[0 +: 3] !== 3'd1) begin
            mismatched++;
            $display("FAIL exhaust_return: avail0=%b cred0=%0d want 1/1", bus.avail[0], bus.credit_cnt[0 +: 3]);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 2; k++) begin
            bus.alloc = 5'b00010;
            tick();
            bus.alloc = '0;
            tick();
        end
        bus.alloc      = 5'b00010;
        bus.credit_ret = 5'b00010;
        tick();
        bus.alloc      = '0;
        bus.credit_ret = '0;
        compared++;
        if (bus.credit_cnt[3 +: 3] !== 3'd2 || bus.avail[1] !== 1'b0 || bus.err !== 1'b0) begin
            mismatched++;
            $display("FAIL simul_grant_ret: cred1=%0d avail1=%b err=%b want 2/0/0",
                     bus.credit_cnt[3 +: 3], bus.avail[1], bus.err);
        end
        tick();
        compared++;
        if (bus.avail[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL simul_free: avail1=%b want 1", bus.avail[1]);
        end
    endtask

    task automatic test_illegal();
        bus.alloc = 5'b00010;
        tick();
        tick();
        bus.alloc = '0;
        compared++;
        if (bus.credit_cnt[3 +: 3] !== 3'd1 || bus.err !== 1'b1) begin
            mismatched++;
            $display("FAIL illegal_grant: cred1=%0d err=%b want 1/1", bus.credit_cnt[3 +: 3], bus.err);
        end
        repeat (10) tick();
        compared++;
        if (bus.err !== 1'b1 || bus.credit_cnt !== exp_cnt()) begin
            mismatched++;
            $display("FAIL illegal_sticky: err=%b cnt=%o want 1/%o", bus.err, bus.credit_cnt, exp_cnt());
        end
    endtask

    task automatic test_overflow();
        pulse_reset();
        bus.credit_ret = 5'b00100;
        tick();
        bus.credit_ret = '0;
        compared++;
        if (bus.credit_cnt[6 +: 3] !== 3'd4 || bus.err !== 1'b1) begin
            mismatched++;
            $display("FAIL overflow: cred2=%0d err=%b want 4/1", bus.credit_cnt[6 +: 3], bus.err);
        end
    endtask

    task automatic test_edge_enable();
        pulse_reset();
        bus.port_en = 5'b01111;
        #1;
        compared++;
        if (bus.avail !== 5'b01111) begin
            mismatched++;
            $display("FAIL edge_en_static: got %b want 01111", bus.avail);
        end
        for (int k = 0; k < 60; k++) begin
            bus.alloc      = 5'($urandom) & exp_avail();
            bus.credit_ret = 5'($urandom) & 5'b10000;
            tick();
            compared++;
            if (bus.avail[4] !== 1'b0 || bus.avail !== exp_avail() || bus.credit_cnt !== exp_cnt()) begin
                mismatched++;
                $display("FAIL edge_en cyc %0d: avail=%b cnt=%o want %b/%o",
                         cyc, bus.avail, bus.credit_cnt, exp_avail(), exp_cnt());
            end
        end
        bus.alloc      = '0;
        bus.credit_ret = '0;
    endtask

    task automatic test_random();
        bus.port_en = 5'b11111;
        pulse_reset();
        for (int k = 0; k < 400; k++) begin
            if (k == 200) bus.port_en = 5'($urandom) | 5'b00001;
            bus.alloc = 5'($urandom) & exp_avail();
            if ($urandom_range(0, 24) == 0) bus.alloc = 5'($urandom);
            for (int i = 0; i < NP; i++)
                bus.credit_ret[i] = (cred[i] < CMAX) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) bus.credit_ret = 5'($urandom);
            tick();
            compared++;
            if (bus.avail !== exp_avail() || bus.credit_cnt !== exp_cnt() || bus.err !== m_err) begin
                mismatched++;
                $display("FAIL random cyc %0d: avail=%b cnt=%o err=%b want %b/%o/%b",
                         cyc, bus.avail, bus.credit_cnt, bus.err, exp_avail(), exp_cnt(), m_err);
            end
        end
        bus.alloc      = '0;
        bus.credit_ret = '0;
    endtask

    task automatic test_async_reset();
        bus.port_en = 5'b11111;
        bus.alloc   = 5'b11111;
        tick();
        bus.alloc = 5'b00011;
        tick();
        bus.alloc = '0;
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (bus.avail !== 5'b11111 || bus.credit_cnt !== 15'o44444 || bus.err !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: avail=%b cnt=%o err=%b want 11111/44444/0",
                     bus.avail, bus.credit_cnt, bus.err);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        bus.alloc = 5'b00100;
        tick();
        bus.alloc = '0;
        compared++;
        if (bus.avail !== 5'b11011 || bus.credit_cnt !== exp_cnt()) begin
            mismatched++;
            $display("FAIL post_reset_grant: avail=%b cnt=%o want 11011/%o", bus.avail, bus.credit_cnt, exp_cnt());
        end
    endtask

    initial begin
        bus.alloc      = '0;
        bus.credit_ret = '0;
        bus.port_en    = '1;
        reset          = 1'b1;
        test_reset();
        test_serialization();
        test_exhaustion();
        test_simultaneous();
        test_illegal();
        test_overflow();
        test_edge_enable();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/out_port_tracker.md
# out_port_tracker

Output-port availability tracker for the router's switch-allocation stage. It produces the `avail` vector consumed by the port allocator and consumes the allocator's `alloc` grant vector. Per output port, it tracks downstream buffer credits and link serialization occupancy. A port is advertised available only when it is enabled, has at least one credit, and is not still serializing a previous flit.

## Interface
Parameters:
- NUM_PORT, `NUM_PORT (5): number of router output ports.
- CREDIT_MAX, 4: downstream buffer depth per port; credit counter reset value.
- CW, 3: credit counter width; must satisfy 2^CW > CREDIT_MAX.
- SER_CYC, 2: cycles a port is occupied per granted flit; legal range 1..15.

Ports:
- clk  in  1  router clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- alloc  in  NUM_PORT  one-hot-per-port grant vector from the allocator, sampled each cycle.
- credit_ret  in  NUM_PORT  one credit returned by the downstream router per set bit, per cycle.
- port_en  in  NUM_PORT  static enable; 0 for unconnected (mesh edge) ports.
- avail  out  NUM_PORT  port i may be granted this cycle.
- credit_cnt  out  NUM_PORT*CW  packed current credit counts; port i occupies bits [i*CW +: CW].
- err  out  1  sticky protocol-error flag.

## Operation
- Per-port state:
  - cred[i]: 0..CREDIT_MAX.
  - ser[i]: 0..SER_CYC-1, the remaining busy cycles.
- avail[i] = port_en[i] & (cred[i] != 0) & (ser[i] == 0).
  - Purely a function of registers and port_en; there is no combinational path from alloc or credit_ret.
- Accepted grant: alloc[i]=1 and avail[i]=1.
  - cred[i] decrements by 1.
  - ser[i] loads SER_CYC-1.
- Illegal grant: alloc[i]=1 and avail[i]=0.
  - The grant is ignored; no state change for port i.
  - err is set.
- ser[i] != 0 with no accepted grant: ser[i] decrements by 1.
- credit_ret[i]=1 increments cred[i].
- Accepted grant and credit return on the same port in the same cycle: net cred[i] is unchanged, and ser[i] still loads.
- Credit return with cred[i]==CREDIT_MAX and no simultaneous accepted grant: overflow.
  - cred[i] saturates at CREDIT_MAX.
  - err is set.
- Ports are fully independent; any number of ports may be granted or receive credits in one cycle.
- err clears only on reset.
- Credit returns on disabled ports are still counted, but the port is never advertised.

## Timing
- Reset values, asserted asynchronously:
  - cred[i]=CREDIT_MAX and ser[i]=0.
  - err=0 and credit_cnt=all ports CREDIT_MAX.
  - avail=port_en.
- Reset mid-operation discards outstanding occupancy and restores full credits. The downstream router is reset together with this block.
- Grant accepted at edge t:
  - avail[i] is 0 for cycles t+1 .. t+SER_CYC-1.
  - avail[i] returns to 1 in cycle t+SER_CYC if cred[i] is still > 0.
- SER_CYC=1: a port may be granted on every cycle while credits remain.
- cred[i] reaches 0 after grant at t: avail[i] stays 0 until a credit return at edge u. avail[i] is then 1 in cycle u+1, provided ser[i]==0 by then.
- Latency from credit_ret to credit_cnt update: 1 cycle.

## Structure
- `NUM_PORT already lives in global.v.
- Add `CREDIT_MAX and `SER_CYC defaults to global.v so router, allocator and downstream buffer agree.
- One sub-module is natural: port_credit_ctr.
  - Holds a single port's cred/ser registers, its avail bit and its error pulse.
  - The top instantiates NUM_PORT copies with a generate loop.
  - The top ORs the error pulses into the sticky err register.

## Test plan
- Reset check: port_en=11111; release reset. Required: avail=11111, every credit_cnt field=4, err=0.
- Serialization (SER_CYC=2): alloc=10000 for one cycle. Required: avail=01111 the next cycle, 11111 the cycle after, port-4 credit=3.
- Credit exhaustion: grant port 0 four times at legal spacing. Required: avail[0]=0 with cred=0. Then credit_ret=00001 for one cycle. Required: avail[0]=1 one cycle later, cred=1.
- Simultaneous grant and return on port 1 with cred=2. Required: cred stays 2, avail[1]=0 for one cycle, err=0.
- Illegal grant: alloc=00010 while avail[1]=0. Required: cred[1] unchanged, err=1, and err still 1 after 10 idle cycles.
- Overflow and edge enable:
  - credit_ret=00100 at cred=4. Required: cred stays 4, err=1.
  - port_en=01111. Required: avail[4]=0 permanently.
  - Asynchronous reset mid-sequence. Required: all outputs return to reset values without waiting for a clock edge.
